// File: rtl/room_pkg.sv
// room_pkg: shared types, room count and the room adjacency table.
package room_pkg;
  localparam int NUM_ROOMS = 8;
  typedef enum logic [2:0] {N, S, W, E, WARP} dir_t;
  typedef enum logic [1:0] {PLAY, FADE_OUT, SWAP, FADE_IN} state_t;
  // Each entry is {valid, room[2:0]}, columns ordered N, S, W, E.
  localparam logic [3:0] NBR_TABLE [NUM_ROOMS][4] = '{
    '{4'hA, 4'h0, 4'h0, 4'h9},
    '{4'h0, 4'h0, 4'h8, 4'hB},
    '{4'h0, 4'h8, 4'h0, 4'h0},
    '{4'h0, 4'hC, 4'h9, 4'h0},
    '{4'hB, 4'h0, 4'h0, 4'hD},
    '{4'hE, 4'h0, 4'hC, 4'hF},
    '{4'h0, 4'hD, 4'h0, 4'h0},
    '{4'h0, 4'h0, 4'hD, 4'h0}
  };
endpackage

// File: rtl/room_controller_exit_detect.sv
// exit_detect: combinational door-edge check with N > S > W > E priority over valid neighbours.
module exit_detect
  import room_pkg::*;
#(
  parameter logic [9:0] EDGE_N = 10'd40,
  parameter logic [9:0] EDGE_S = 10'd424,
  parameter logic [9:0] EDGE_W = 10'd8,
  parameter logic [9:0] EDGE_E = 10'd600
) (
  input  logic [2:0] room,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       hit,
  output dir_t       dir,
  output logic [2:0] target
);
  logic n_ok, s_ok, w_ok, e_ok;
  always_comb begin
    n_ok = player_y < EDGE_N && NBR_TABLE[room][0][3];
    s_ok = player_y > EDGE_S && NBR_TABLE[room][1][3];
    w_ok = player_x < EDGE_W && NBR_TABLE[room][2][3];
    e_ok = player_x > EDGE_E && NBR_TABLE[room][3][3];
    hit = n_ok | s_ok | w_ok | e_ok;
    dir = n_ok ? N : s_ok ? S : w_ok ? W : E;
    target = n_ok ? NBR_TABLE[room][0][2:0] : s_ok ? NBR_TABLE[room][1][2:0] :
             w_ok ? NBR_TABLE[room][2][2:0] : NBR_TABLE[room][3][2:0];
  end
endmodule

// File: rtl/room_controller.sv
// room_controller: owns the room index, detects door exits / debug warps and runs the blank-swap-blank transition.
module room_controller
  import room_pkg::*;
#(
  parameter logic [2:0] START_ROOM   = 3'd0,
  parameter int         BLANK_FRAMES = 16,
  parameter logic [9:0] EDGE_N       = 10'd40,
  parameter logic [9:0] EDGE_S       = 10'd424,
  parameter logic [9:0] EDGE_W       = 10'd8,
  parameter logic [9:0] EDGE_E       = 10'd600,
  parameter logic [9:0] SPAWN_N_Y    = 10'd72,
  parameter logic [9:0] SPAWN_S_Y    = 10'd400,
  parameter logic [9:0] SPAWN_W_X    = 10'd32,
  parameter logic [9:0] SPAWN_E_X    = 10'd576,
  parameter logic [9:0] WARP_X       = 10'd304,
  parameter logic [9:0] WARP_Y       = 10'd224
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       warp_req,
  input  logic [2:0] warp_room,
  output logic       warp_ack,
  output logic [2:0] room,
  output logic       blank,
  output logic       busy,
  output logic       player_set,
  output logic [9:0] player_new_x,
  output logic [9:0] player_new_y
);
  localparam logic [7:0] LAST = 8'(BLANK_FRAMES - 1);
  if (SPAWN_N_Y < EDGE_N || SPAWN_N_Y > EDGE_S || SPAWN_S_Y < EDGE_N || SPAWN_S_Y > EDGE_S ||
      SPAWN_W_X < EDGE_W || SPAWN_W_X > EDGE_E || SPAWN_E_X < EDGE_W || SPAWN_E_X > EDGE_E ||
      BLANK_FRAMES < 1 || BLANK_FRAMES > 255) begin : g_bad_params
    $error("room_controller: spawn point inside an edge window or BLANK_FRAMES out of range");
  end
  state_t     state, next;
  dir_t       hit_dir, dir_q;
  logic       hit, exit_go, warp_go, last, warp_armed;
  logic [2:0] hit_target, target_q;
  logic [7:0] cnt;
  logic [9:0] px_q, py_q;
  exit_detect #(.EDGE_N(EDGE_N), .EDGE_S(EDGE_S), .EDGE_W(EDGE_W), .EDGE_E(EDGE_E)) u_exit (
    .room(room), .player_x(player_x), .player_y(player_y),
    .hit(hit), .dir(hit_dir), .target(hit_target)
  );
  // A held warp_req is only honoured again once it has been released.
  always_comb begin
    exit_go = state == PLAY && frame_tick && hit;
    warp_go = state == PLAY && warp_req && warp_armed && !exit_go;
    last = frame_tick && cnt == LAST;
    next = (exit_go || warp_go) ? FADE_OUT :
           (state == FADE_OUT && last) ? SWAP :
           state == SWAP ? FADE_IN :
           (state == FADE_IN && last) ? PLAY : state;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= PLAY;
      room <= START_ROOM;
      blank <= 1'b0;
      busy <= 1'b0;
      player_set <= 1'b0;
      warp_ack <= 1'b0;
      player_new_x <= '0;
      player_new_y <= '0;
      cnt <= '0;
      dir_q <= N;
      target_q <= '0;
      px_q <= '0;
      py_q <= '0;
      warp_armed <= 1'b1;
    end else begin
      state <= next;
      blank <= next != PLAY;
      busy <= next != PLAY;
      player_set <= next == SWAP;
      warp_ack <= warp_go;
      warp_armed <= warp_go ? 1'b0 : !warp_req ? 1'b1 : warp_armed;
      cnt <= state != next ? 8'd0 :
             ((state == FADE_OUT || state == FADE_IN) && frame_tick) ? cnt + 8'd1 : cnt;
      if (exit_go) begin
        dir_q <= hit_dir;
        target_q <= hit_target;
        px_q <= player_x;
        py_q <= player_y;
      end else if (warp_go) begin
        dir_q <= WARP;
        target_q <= warp_room;
      end
      if (next == SWAP) begin
        room <= target_q;
        player_new_x <= (dir_q == N || dir_q == S) ? px_q : dir_q == W ? SPAWN_E_X :
                        dir_q == E ? SPAWN_W_X : WARP_X;
        player_new_y <= dir_q == N ? SPAWN_S_Y : dir_q == S ? SPAWN_N_Y :
                        dir_q == WARP ? WARP_Y : py_q;
      end
    end
  end
endmodule

// File: tb/tb_room_controller.sv
// tb_room_controller: directed stimulus with a scoreboard of expected player_set and warp_ack events.
module tb_room_controller;
  logic       Clk = 0, Reset_n = 0, frame_tick = 0, warp_req = 0;
  logic [9:0] player_x = 10'd300, player_y = 10'd200;
  logic [2:0] warp_room = 0;
  logic       warp_ack, blank, busy, player_set;
  logic [2:0] room;
  logic [9:0] player_new_x, player_new_y;
  int checks = 0, failures = 0;
  typedef struct {int r; int x; int y;} swap_t;
  swap_t sb_swap[$];
  int    sb_ack[$];

  room_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .player_x(player_x),
    .player_y(player_y), .warp_req(warp_req), .warp_room(warp_room), .warp_ack(warp_ack),
    .room(room), .blank(blank), .busy(busy), .player_set(player_set),
    .player_new_x(player_new_x), .player_new_y(player_new_y)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_swap(input int r, input int x, input int y);
    swap_t s;
    s.r = r; s.x = x; s.y = y;
    sb_swap.push_back(s);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge Clk) frame_tick = 1;
      @(negedge Clk) frame_tick = 0;
      @(negedge Clk);
    end
  endtask

  task automatic run_transition(input int r);
    tick_n(16);
    check("room_after_swap", room, r);
    check("blank_after_swap", blank, 1);
    tick_n(15);
    check("busy_fade_in_last", busy, 1);
    tick_n(1);
    check("busy_done", busy, 0);
    check("blank_done", blank, 0);
  endtask

  always @(negedge Clk) begin
    if (Reset_n && player_set) begin
      if (sb_swap.size() == 0) begin
        checks++; failures++;
        $display("FAIL swap_unexpected: got player_set=1 expected 0");
      end else begin
        swap_t s;
        s = sb_swap.pop_front();
        check("swap_room", room, s.r);
        check("swap_new_x", player_new_x, s.x);
        check("swap_new_y", player_new_y, s.y);
      end
    end
    if (Reset_n && warp_ack) begin
      if (sb_ack.size() == 0) begin
        checks++; failures++;
        $display("FAIL ack_unexpected: got warp_ack=1 expected 0");
      end else begin
        void'(sb_ack.pop_front());
        check("ack_busy", busy, 1);
      end
    end
  end

  initial begin
    #1;
    check("rst_room", room, 0);
    check("rst_blank", blank, 0);
    check("rst_busy", busy, 0);
    check("rst_set", player_set, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    tick_n(1);
    check("play_busy", busy, 0);
    check("play_room", room, 0);
    // room 0 north exit -> room 2
    player_y = 10'd30;
    push_swap(2, 300, 400);
    tick_n(1);
    player_y = 10'd200;
    check("fade_out_blank", blank, 1);
    check("fade_out_busy", busy, 1);
    run_transition(2);
    // west edge in room 2 has no door
    player_x = 10'd4;
    tick_n(5);
    check("nodoor_busy", busy, 0);
    check("nodoor_blank", blank, 0);
    check("nodoor_room", room, 2);
    player_x = 10'd300;
    // warp to 5 with warp_req held throughout
    push_swap(5, 304, 224);
    sb_ack.push_back(5);
    @(negedge Clk) begin warp_req = 1; warp_room = 3'd5; end
    @(negedge Clk);
    check("warp_busy", busy, 1);
    run_transition(5);
    tick_n(2);
    check("held_no_rewarp", busy, 0);
    warp_req = 0;
    // room 5: north and east on the same tick, north wins
    player_y = 10'd30; player_x = 10'd610;
    push_swap(6, 610, 400);
    tick_n(1);
    player_y = 10'd200; player_x = 10'd300;
    run_transition(6);
    // warp to 7, then re-assert for a warp to the current room
    push_swap(7, 304, 224);
    sb_ack.push_back(7);
    @(negedge Clk) begin warp_req = 1; warp_room = 3'd7; end
    run_transition(7);
    tick_n(1);
    check("held_idle", busy, 0);
    @(negedge Clk) warp_req = 0;
    push_swap(7, 304, 224);
    sb_ack.push_back(7);
    @(negedge Clk) warp_req = 1;
    run_transition(7);
    @(negedge Clk) warp_req = 0;
    // exit and warp on the same cycle: exit first, warp acked afterwards
    player_x = 10'd4; warp_room = 3'd1;
    push_swap(5, 576, 200);
    sb_ack.push_back(1);
    push_swap(1, 304, 224);
    @(negedge Clk) begin frame_tick = 1; warp_req = 1; end
    @(negedge Clk) begin frame_tick = 0; player_x = 10'd300; end
    check("exit_over_warp_busy", busy, 1);
    check("exit_over_warp_pending", sb_ack.size(), 1);
    tick_n(16);
    check("exit_room", room, 5);
    tick_n(16);
    run_transition(1);
    warp_req = 0;
    // room 1 east exit, reset during FADE_IN
    player_x = 10'd610;
    push_swap(3, 32, 200);
    tick_n(1);
    player_x = 10'd300;
    tick_n(19);
    check("pre_reset_busy", busy, 1);
    @(negedge Clk) Reset_n = 0;
    #1;
    check("mid_rst_room", room, 0);
    check("mid_rst_blank", blank, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_new_x", player_new_x, 0);
    check("mid_rst_new_y", player_new_y, 0);
    @(negedge Clk) Reset_n = 1;
    tick_n(2);
    check("post_rst_busy", busy, 0);
    check("post_rst_room", room, 0);
    check("sb_swap_empty", sb_swap.size(), 0);
    check("sb_ack_empty", sb_ack.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
